// File: rtl/l2cache_2way_if.sv
// l2cache_2way_if: L1 request ports, memory port and performance counters of the L2
interface l2cache_2way_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
);
  logic              Icache_read;
  logic [ADDR_W-1:0] Icache_addr;
  logic              Icache_ready;
  logic [DATA_W-1:0] Icache_rdata;
  logic              Dcache_read;
  logic              Dcache_write;
  logic [ADDR_W-1:0] Dcache_addr;
  logic [DATA_W-1:0] Dcache_wdata;
  logic              Dcache_ready;
  logic [DATA_W-1:0] Dcache_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  I_access_cnt;
  logic [CNT_W-1:0]  I_miss_cnt;
  logic [CNT_W-1:0]  D_access_cnt;
  logic [CNT_W-1:0]  D_miss_cnt;
  modport slave (
    input  Icache_read, Icache_addr, Dcache_read, Dcache_write, Dcache_addr, Dcache_wdata,
           mem_rdata, mem_ready,
    output Icache_ready, Icache_rdata, Dcache_ready, Dcache_rdata,
           mem_read, mem_write, mem_addr, mem_wdata,
           I_access_cnt, I_miss_cnt, D_access_cnt, D_miss_cnt
  );
  modport master (
    output Icache_read, Icache_addr, Dcache_read, Dcache_write, Dcache_addr, Dcache_wdata,
           mem_rdata, mem_ready,
    input  Icache_ready, Icache_rdata, Dcache_ready, Dcache_rdata,
           mem_read, mem_write, mem_addr, mem_wdata,
           I_access_cnt, I_miss_cnt, D_access_cnt, D_miss_cnt
  );
endinterface

// File: rtl/l2cache_2way.sv
// l2cache_2way: unified 2-way write-back L2 shared by I and D L1s with round-robin arbitration
module l2cache_2way #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           proc_reset,
  l2cache_2way_if.slave  bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;
  state_t state_q, state_d;
  logic [1:0]        valid_q [SETS];
  logic [1:0]        dirty_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [DATA_W-1:0] data_q [2][SETS];
  logic              gnt_d_q, req_wr_q, vic_q, last_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, line_q;
  logic [CNT_W-1:0]  i_acc_q, i_mis_q, d_acc_q, d_mis_q;
  logic              req_i, req_d, any_req, sel_d, wr, hit, hit_way, vic, iway;
  logic [1:0]        match;
  logic [ADDR_W-1:0] addr;
  logic [INDEX_W-1:0] idx, ridx;
  logic [TAG_W-1:0]  tg;
  assign req_i   = bus.Icache_read;
  assign req_d   = bus.Dcache_read | bus.Dcache_write;
  assign any_req = req_i | req_d;
  assign sel_d   = req_d & (~req_i | ~last_d_q);
  assign wr      = sel_d & bus.Dcache_write;
  assign addr    = sel_d ? bus.Dcache_addr : bus.Icache_addr;
  assign idx     = addr[INDEX_W-1:0];
  assign tg      = addr[ADDR_W-1:INDEX_W];
  assign ridx    = addr_q[INDEX_W-1:0];
  assign match[0] = valid_q[idx][0] && tag_q[0][idx] == tg;
  assign match[1] = valid_q[idx][1] && tag_q[1][idx] == tg;
  assign hit     = |match;
  assign hit_way = match[1];
  assign vic     = ~valid_q[idx][0] ? 1'b0 : ~valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign iway    = hit ? hit_way : vic;
  assign bus.I_access_cnt = i_acc_q;
  assign bus.I_miss_cnt   = i_mis_q;
  assign bus.D_access_cnt = d_acc_q;
  assign bus.D_miss_cnt   = d_mis_q;
  // state register
  always_ff @(posedge clk)
    state_q <= proc_reset ? IDLE : state_d;
  // next state: a write that misses on a clean victim completes without memory traffic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = hit ? RESP : dirty_q[idx][vic] ? WB : wr ? RESP : FILL;
      WB:      if (bus.mem_ready) state_d = req_wr_q ? RESP : FILL;
      FILL:    if (bus.mem_ready) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; write-back address is rebuilt from the victim's stored tag
  always_comb begin
    bus.mem_read     = state_q == FILL;
    bus.mem_write    = state_q == WB;
    bus.mem_addr     = state_q == WB ? {tag_q[vic_q][ridx], ridx} : state_q == FILL ? addr_q : '0;
    bus.mem_wdata    = state_q == WB ? data_q[vic_q][ridx] : '0;
    bus.Icache_ready = state_q == RESP && !gnt_d_q;
    bus.Dcache_ready = state_q == RESP && gnt_d_q;
    bus.Icache_rdata = line_q;
    bus.Dcache_rdata = line_q;
  end
  // control state: grant capture, valid/dirty/LRU bookkeeping, counters, arbitration pointer
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      valid_q  <= '{default: '0};
      dirty_q  <= '{default: '0};
      lru_q    <= '0;
      last_d_q <= 1'b0;
      gnt_d_q  <= 1'b0;
      req_wr_q <= 1'b0;
      vic_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      i_acc_q  <= '0;
      i_mis_q  <= '0;
      d_acc_q  <= '0;
      d_mis_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_d_q  <= sel_d;
          req_wr_q <= wr;
          addr_q   <= addr;
          wdata_q  <= bus.Dcache_wdata;
          vic_q    <= vic;
          if (sel_d && ~&d_acc_q) d_acc_q <= d_acc_q + CNT_W'(1);
          if (!sel_d && ~&i_acc_q) i_acc_q <= i_acc_q + CNT_W'(1);
          if (hit) begin
            lru_q[idx] <= ~hit_way;
            if (wr) dirty_q[idx][hit_way] <= 1'b1;
            else line_q <= data_q[hit_way][idx];
          end else begin
            if (sel_d && ~&d_mis_q) d_mis_q <= d_mis_q + CNT_W'(1);
            if (!sel_d && ~&i_mis_q) i_mis_q <= i_mis_q + CNT_W'(1);
            if (wr && !dirty_q[idx][vic]) begin
              valid_q[idx][vic] <= 1'b1;
              dirty_q[idx][vic] <= 1'b1;
              lru_q[idx]        <= ~vic;
            end
          end
        end
        WB: if (bus.mem_ready) begin
          dirty_q[ridx][vic_q] <= req_wr_q;
          if (req_wr_q) lru_q[ridx] <= ~vic_q;
        end
        FILL: if (bus.mem_ready) begin
          valid_q[ridx][vic_q] <= 1'b1;
          dirty_q[ridx][vic_q] <= 1'b0;
          lru_q[ridx]          <= ~vic_q;
          line_q               <= bus.mem_rdata;
        end
        default: last_d_q <= gnt_d_q;
      endcase
    end
  end
  // data and tag arrays: written on write hits, write installs and fills
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_req && wr && (hit || !dirty_q[idx][vic])) begin
      data_q[iway][idx] <= bus.Dcache_wdata;
      tag_q[iway][idx]  <= tg;
    end else if (((state_q == WB && req_wr_q) || state_q == FILL) && bus.mem_ready) begin
      data_q[vic_q][ridx] <= state_q == FILL ? bus.mem_rdata : wdata_q;
      tag_q[vic_q][ridx]  <= addr_q[ADDR_W-1:INDEX_W];
    end
  end
endmodule

// File: tb/tb_l2cache_2way.sv
// tb_l2cache_2way: randomized check of the L2 against a recency-list cache model
module tb_l2cache_2way;
  localparam int AW = 28, DW = 128, IW = 6, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, proc_reset = 1;
  always #5 clk = ~clk;
  l2cache_2way_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
  l2cache_2way #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .proc_reset(proc_reset), .bus(bus));
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  typedef struct {bit wr; logic [AW-1:0] addr; logic [DW-1:0] data;} mtx_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; bit dirty; int t;} cl_t;
  logic [DW-1:0] mem_a   [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  mtx_t log_q[$], exp_q[$];
  cl_t  cache_m[$];
  int   tick = 0, acc[2], mis[2];
  bit   last_d = 0, mem_hold = 0;
  int   wcnt = 0;
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {4{4'h9, a}};
  endfunction
  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  // external memory: random latency, stores write-backs, logs every transaction
  initial begin
    bus.mem_ready = 0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if ((bus.mem_read || bus.mem_write) && !mem_hold && wcnt == 0) begin
        check("mem_excl", bus.mem_read & bus.mem_write, 0);
        if (bus.mem_write) begin
          mem_a[bus.mem_addr] = bus.mem_wdata;
          log_q.push_back('{1, bus.mem_addr, bus.mem_wdata});
        end else begin
          bus.mem_rdata = mem_a.exists(bus.mem_addr) ? mem_a[bus.mem_addr] : init_val(bus.mem_addr);
          log_q.push_back('{0, bus.mem_addr, bus.mem_rdata});
        end
        bus.mem_ready = 1;
        wcnt = $urandom_range(0, 2);
      end else begin
        bus.mem_ready = 0;
        if ((bus.mem_read || bus.mem_write) && wcnt > 0) wcnt--;
      end
    end
  end
  task automatic mreset();
    cache_m.delete();
    acc = '{0, 0};
    mis = '{0, 0};
    last_d = 0;
  endtask
  // reference: each set holds up to two lines; a miss in a full set evicts the least recently touched
  task automatic model(input bit d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       output bit hit, output logic [DW-1:0] rd);
    int h = -1, n = 0, old = -1;
    cl_t e;
    tick++;
    acc[d] = acc[d] == CMAX ? CMAX : acc[d] + 1;
    foreach (cache_m[k])
      if (cache_m[k].addr[IW-1:0] == a[IW-1:0]) begin
        n++;
        if (cache_m[k].addr == a) h = k;
        if (old < 0 || cache_m[k].t < cache_m[old].t) old = k;
      end
    hit = h >= 0;
    rd = '0;
    if (hit) begin
      e = cache_m[h];
      if (wr) begin e.data = wd; e.dirty = 1; end
      rd = e.data;
      e.t = tick;
      cache_m[h] = e;
    end else begin
      mis[d] = mis[d] == CMAX ? CMAX : mis[d] + 1;
      if (n == 2) begin
        if (cache_m[old].dirty) begin
          exp_q.push_back('{1, cache_m[old].addr, cache_m[old].data});
          ref_mem[cache_m[old].addr] = cache_m[old].data;
        end
        cache_m.delete(old);
      end
      if (wr) cache_m.push_back('{a, wd, 1, tick});
      else begin
        rd = ref_get(a);
        exp_q.push_back('{0, a, rd});
        cache_m.push_back('{a, rd, 0, tick});
      end
    end
    last_d = d;
  endtask
  task automatic serve(input bit di, input bit dd, input bit dwr, input logic [AW-1:0] ai,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bit first_d, hit_i = 0, hit_d = 0, done_i, done_d, got_first = 0;
    logic [DW-1:0] rd_i = '0, rd_d = '0;
    int cyc = 0;
    exp_q.delete();
    log_q.delete();
    first_d = dd && (!di || !last_d);
    if (first_d) begin
      model(1, dwr, ad, wd, hit_d, rd_d);
      if (di) model(0, 0, ai, '0, hit_i, rd_i);
    end else begin
      model(0, 0, ai, '0, hit_i, rd_i);
      if (dd) model(1, dwr, ad, wd, hit_d, rd_d);
    end
    @(negedge clk);
    bus.Icache_read = di;  bus.Icache_addr = ai;
    bus.Dcache_read = dd & !dwr;  bus.Dcache_write = dd & dwr;
    bus.Dcache_addr = ad;  bus.Dcache_wdata = wd;
    done_i = !di;
    done_d = !dd;
    while (!(done_i && done_d) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (!got_first && (bus.Icache_ready || bus.Dcache_ready)) begin
        got_first = 1;
        check("grant", bus.Dcache_ready, first_d);
      end
      if (bus.Icache_ready && !done_i) begin
        done_i = 1;
        bus.Icache_read = 0;
        check("i_rdata", bus.Icache_rdata, rd_i);
        if (!dd && hit_i) check("i_hit_lat", cyc, 1);
      end
      if (bus.Dcache_ready && !done_d) begin
        done_d = 1;
        bus.Dcache_read = 0;
        bus.Dcache_write = 0;
        if (!dwr) check("d_rdata", bus.Dcache_rdata, rd_d);
        if (!di && hit_d) check("d_hit_lat", cyc, 1);
      end
    end
    check("completed", {done_i, done_d}, 2'b11);
    @(posedge clk); #1;
    check("ready_pulse", {bus.Icache_ready, bus.Dcache_ready}, 0);
    check("mem_n", log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      check("mem_kind", log_q[k].wr, exp_q[k].wr);
      check("mem_addr", log_q[k].addr, exp_q[k].addr);
      if (exp_q[k].wr) check("mem_wdata", log_q[k].data, exp_q[k].data);
    end
    check("I_access_cnt", bus.I_access_cnt, acc[0]);
    check("I_miss_cnt", bus.I_miss_cnt, mis[0]);
    check("D_access_cnt", bus.D_access_cnt, acc[1]);
    check("D_miss_cnt", bus.D_miss_cnt, mis[1]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    proc_reset = 1;
    bus.Icache_read = 0;
    bus.Dcache_read = 0;
    bus.Dcache_write = 0;
    @(negedge clk);
    proc_reset = 0;
    mreset();
  endtask
  initial begin
    int cyc;
    logic [DW-1:0] ones;
    bus.Icache_read = 0;  bus.Icache_addr = '0;
    bus.Dcache_read = 0;  bus.Dcache_write = 0;
    bus.Dcache_addr = '0; bus.Dcache_wdata = '0;
    mreset();
    mem_a[28'h40] = {16{8'hA5}};
    ref_mem[28'h40] = {16{8'hA5}};
    ones = {32{4'h1}};
    @(posedge clk); #1;
    check("rst_ready", {bus.Icache_ready, bus.Dcache_ready}, 0);
    check("rst_mem", {bus.mem_read, bus.mem_write}, 0);
    check("rst_irdata", bus.Icache_rdata, 0);
    check("rst_drdata", bus.Dcache_rdata, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cnt", {bus.I_access_cnt, bus.I_miss_cnt, bus.D_access_cnt, bus.D_miss_cnt}, 0);
    @(negedge clk);
    proc_reset = 0;
    serve(1, 0, 0, 28'h40, '0, '0);
    serve(1, 0, 0, 28'h40, '0, '0);
    serve(0, 1, 1, '0, 28'h41, ones);
    serve(1, 0, 0, 28'h41, '0, '0);
    serve(0, 1, 1, '0, 28'h40, {4{32'hCAFE_0040}});
    serve(0, 1, 1, '0, 28'h80, {4{32'hBEEF_0080}});
    serve(1, 0, 0, 28'h40, '0, '0);
    serve(0, 1, 0, '0, 28'hC0, '0);
    do_reset();
    serve(1, 1, 0, 28'h200, 28'h240, '0);
    serve(0, 1, 0, '0, 28'h280, '0);
    serve(1, 1, 0, 28'h2C0, 28'h300, '0);
    do_reset();
    mem_hold = 1;
    @(negedge clk);
    bus.Icache_read = 1;
    bus.Icache_addr = 28'h100;
    cyc = 0;
    while (!bus.mem_read && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("fill_pending", bus.mem_read, 1);
    @(negedge clk);
    proc_reset = 1;
    bus.Icache_read = 0;
    @(posedge clk); #1;
    check("rst_drop_mem_read", bus.mem_read, 0);
    @(negedge clk);
    proc_reset = 0;
    mem_hold = 0;
    mreset();
    serve(1, 0, 0, 28'h100, '0, '0);
    for (int i = 0; i < 20; i++) serve(1, 0, 0, 28'h100, '0, '0);
    for (int i = 0; i < 150; i++) begin
      int mode;
      logic [AW-1:0] ai, ad;
      mode = $urandom_range(0, 2);
      ai = (AW'($urandom_range(0, 3)) << IW) | AW'($urandom_range(0, 3));
      ad = (AW'($urandom_range(0, 3)) << IW) | AW'($urandom_range(0, 3));
      serve(mode != 1, mode != 0, 1'($urandom_range(0, 1)), ai, ad,
            {$urandom, $urandom, $urandom, $urandom});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
